memory_arbiter_io: RTL and testbench
====================================

# memory_arbiter_io

Two-requestor, multi-cycle memory port controller for the multi-cycle/pipelined CPU. Arbitrates between the instruction-fetch and data (load/store) requestors, drives a single shared memory over one address bus and one tri-state data bus, and waits for memory completion via `input_ready`. Returns registered read data and one-cycle acknowledge pulses to each requestor. Sits between the datapath/control and the testbench memory model.

## Interface
- `WIDTH`, 16: address and data width in bits.
- `TIMEOUT`, 15: maximum number of ACCESS cycles before abort; used only with `MEMIO_TIMEOUT_EN`.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `f_req`  in  1  fetch request; held until `f_ack`.
- `f_addr`  in  WIDTH  fetch address.
- `f_ack`  out  1  one-cycle fetch completion pulse.
- `f_rdata`  out  WIDTH  registered fetched word.
- `d_req`  in  1  data request; held until `d_ack`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  WIDTH  data address.
- `d_wdata`  in  WIDTH  store data.
- `d_ack`  out  1  one-cycle data completion pulse.
- `d_rdata`  out  WIDTH  registered load word.
- `address`  out  WIDTH  memory address.
- `read_m`  out  1  memory read strobe.
- `write_m`  out  1  memory write strobe.
- `data`  inout  WIDTH  shared memory data bus.
- `input_ready`  in  1  memory completion, sampled in ACCESS only.
- `busy`  out  1  high in ACCESS and DONE.
- `err`  out  1  one-cycle timeout pulse, coincident with the aborted ack.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: with no request, the state stays IDLE. With one request, that request is granted. With both `f_req` and `d_req`, data wins unless the two previous grants were data while `f_req` was pending. In that case fetch wins (anti-starvation; the data-streak counter saturates at 2 and clears on any fetch grant).
- On grant: latch the owner, address, `d_we` and `d_wdata`; next state is ACCESS.
- ACCESS: `address` = latched address. `read_m` = 1 for fetch or load. `write_m` = 1 for store. `data` is driven with the latched wdata only for a store in ACCESS; otherwise `data` is high-Z.
- On `input_ready` in ACCESS: for reads, capture `data` into `f_rdata` or `d_rdata` per owner. Next state is DONE.
- DONE: strobes low, bus high-Z, the owner's ack = 1 for exactly this cycle, all requests ignored. Next state is IDLE. Requestors may drop `req` combinationally from ack.
- `input_ready` outside ACCESS is ignored. Rdata registers hold their value until the next completed read by the same owner; stores never modify them.

## Timing
- Reset values: state IDLE; `read_m`, `write_m`, `f_ack`, `d_ack`, `busy`, `err` = 0; `address` = 0; `f_rdata`, `d_rdata` = 0; `data` high-Z; streak counter = 0.
- Reset mid-access: strobes drop and the bus releases immediately (asynchronous); no ack is issued.
- Request sampled in IDLE at edge N gives ACCESS from N. If `input_ready` is high in the first ACCESS cycle, DONE/ack occurs from N+1. Minimum request-to-ack latency is 2 cycles; back-to-back throughput is one access per 3 cycles.
- Strobes are registered state decodes; there are no combinational paths from `f_req`/`d_req` to memory outputs.

## Configuration
- `MEMIO_TIMEOUT_EN` defined: a counter clears on ACCESS entry and increments each ACCESS cycle. When it reaches `TIMEOUT` without `input_ready`, the block goes to DONE with the owner ack and `err` pulsed together. The rdata registers are not updated on abort.
- `MEMIO_TIMEOUT_EN` undefined: ACCESS waits indefinitely, and `err` is tied to 0.

## Structure
- Shared header/package `memio_defs.v`: state encodings, owner encoding (OWN_FETCH, OWN_DATA), and the streak limit constant 2.
- One sub-module, `memio_watchdog` (counter, clear, timeout flag). It is instantiated only under `MEMIO_TIMEOUT_EN`.

## Test plan
- Fetch only, `f_addr`=0x0010, memory returns 0x1234 with 1-cycle `input_ready`: `read_m` high 1 cycle, `f_ack` 2 cycles after the request, `f_rdata`=0x1234.
- Store `d_addr`=0x0020, `d_wdata`=0xBEEF, `input_ready` after 3 cycles: `data`=0xBEEF only while `write_m`=1, then high-Z; `d_ack` pulses; `d_rdata` unchanged.
- `f_req` and `d_req` held continuously: grant order D, D, F, D, D, F; no access lost.
- Load in progress, `reset_n` dropped mid-ACCESS: `read_m`=0 and bus high-Z immediately, no ack; a fresh request after release completes normally.
- With `MEMIO_TIMEOUT_EN`, `TIMEOUT`=4 and `input_ready` never asserted: `d_ack` and `err` pulse together after 4 ACCESS cycles, and `d_rdata` holds its prior value. Without the macro, the block stays in ACCESS and `err`=0.
- `input_ready` pulsed while IDLE or DONE: no state change, no ack.

Source files
------------

// File: rtl/memory_arbiter_io_pkg.sv
// memory_arbiter_io_pkg
// Shared definitions for the memory port controller: FSM state encoding,
// access-owner encoding and the data-streak limit used for fetch
// anti-starvation.
package memory_arbiter_io_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

  // Consecutive contended data grants allowed before fetch is forced in.
  localparam int unsigned STREAK_LIMIT = 2;

endpackage

// File: rtl/memory_arbiter_io_if.sv
// memory_arbiter_io_if
// Requestor-side handshake bundle for memory_arbiter_io.
//   f_req/f_addr        -> fetch request, held until f_ack
//   f_ack/f_rdata       <- one-cycle completion pulse, registered fetched word
//   d_req/d_we/d_addr/d_wdata -> data request (d_we=1 store), held until d_ack
//   d_ack/d_rdata       <- one-cycle completion pulse, registered load word
// master: requestor side (datapath/testbench); slave: the arbiter.
interface memory_arbiter_io_if #(
  parameter int unsigned WIDTH = 16
);

  logic             f_req;
  logic [WIDTH-1:0] f_addr;
  logic             f_ack;
  logic [WIDTH-1:0] f_rdata;

  logic             d_req;
  logic             d_we;
  logic [WIDTH-1:0] d_addr;
  logic [WIDTH-1:0] d_wdata;
  logic             d_ack;
  logic [WIDTH-1:0] d_rdata;

  modport master (
    output f_req, f_addr,
    input  f_ack, f_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_ack, d_rdata
  );

  modport slave (
    input  f_req, f_addr,
    output f_ack, f_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_ack, d_rdata
  );

endinterface

// File: rtl/memory_arbiter_io_watchdog.sv
// memio_watchdog
// ACCESS-cycle counter for the optional access timeout. Only present when
// MEMIO_TIMEOUT_EN is defined.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr_i       : clear the count (held while the arbiter is idle)
//   inc_i       : count one ACCESS cycle
//   expired_o   : this ACCESS cycle is the TIMEOUT-th one
`ifdef MEMIO_TIMEOUT_EN
module memio_watchdog #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Count holds the number of ACCESS cycles already completed, so the
  // TIMEOUT-th cycle sees TIMEOUT-1 and aborts at its closing edge.
  assign expired_o = inc_i && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/memory_arbiter_io.sv
// memory_arbiter_io
// Two-requestor (fetch/data) multi-cycle memory port controller driving one
// shared address bus, read/write strobes and a tri-state data bus.
//   clk, reset_n   : clock, asynchronous active-low reset
//   req_if (slave) : fetch and data request/ack/rdata handshakes
//   address        : latched access address
//   read_m/write_m : memory strobes, registered state decodes
//   data           : shared bus, driven only during a store in ACCESS
//   input_ready    : memory completion, honoured only in ACCESS
//   busy           : high in ACCESS and DONE
//   err            : timeout pulse coincident with the aborted ack
// Optional feature macro: MEMIO_TIMEOUT_EN (access timeout via memio_watchdog).
module memory_arbiter_io
  import memory_arbiter_io_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  memory_arbiter_io_if.slave req_if,
  output logic [WIDTH-1:0]  address,
  output logic              read_m,
  output logic              write_m,
  inout  wire  [WIDTH-1:0]  data,
  input  logic              input_ready,
  output logic              busy,
  output logic              err
);

  if (TIMEOUT == 0) begin : g_timeout_range
    $error("memory_arbiter_io: TIMEOUT must be nonzero");
  end

  state_e           state_q, state_d;
  owner_e           owner_q, owner_d;
  logic             we_q, we_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] f_rdata_q, f_rdata_d;
  logic [WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic [1:0]       streak_q, streak_d;
  logic             grant_data;
  logic             is_store;
  logic             in_access;

  assign is_store  = (owner_q == OWN_DATA) && we_q;
  assign in_access = (state_q == ST_ACCESS);

  assign address        = addr_q;
  assign read_m         = in_access && !is_store;
  assign write_m        = in_access && is_store;
  assign busy           = (state_q != ST_IDLE);
  assign data           = write_m ? wdata_q : 'z;
  assign req_if.f_ack   = (state_q == ST_DONE) && (owner_q == OWN_FETCH);
  assign req_if.d_ack   = (state_q == ST_DONE) && (owner_q == OWN_DATA);
  assign req_if.f_rdata = f_rdata_q;
  assign req_if.d_rdata = d_rdata_q;

`ifdef MEMIO_TIMEOUT_EN
  logic timeout;
  logic err_q, err_d;

  memio_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .rst_n    (reset_n),
    .clr_i    (state_q == ST_IDLE),
    .inc_i    (in_access),
    .expired_o(timeout)
  );

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    f_rdata_d  = f_rdata_q;
    d_rdata_d  = d_rdata_q;
    streak_d   = streak_q;
    grant_data = 1'b0;
`ifdef MEMIO_TIMEOUT_EN
    err_d      = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_if.f_req || req_if.d_req) begin
          grant_data = req_if.d_req &&
                       (!req_if.f_req || (streak_q < 2'(STREAK_LIMIT)));
          state_d = ST_ACCESS;
          if (grant_data) begin
            owner_d = OWN_DATA;
            addr_d  = req_if.d_addr;
            we_d    = req_if.d_we;
            wdata_d = req_if.d_wdata;
            // Only data grants taken over a waiting fetch extend the streak;
            // an uncontended data grant breaks it.
            if (req_if.f_req) begin
              streak_d = (streak_q == 2'(STREAK_LIMIT)) ? streak_q
                                                        : streak_q + 2'd1;
            end else begin
              streak_d = '0;
            end
          end else begin
            owner_d  = OWN_FETCH;
            addr_d   = req_if.f_addr;
            we_d     = 1'b0;
            streak_d = '0;
          end
        end
      end
      ST_ACCESS: begin
        if (input_ready) begin
          state_d = ST_DONE;
          if (!is_store) begin
            if (owner_q == OWN_FETCH) begin
              f_rdata_d = data;
            end else begin
              d_rdata_d = data;
            end
          end
        end
`ifdef MEMIO_TIMEOUT_EN
        else if (timeout) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end
`endif
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_FETCH;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      f_rdata_q <= '0;
      d_rdata_q <= '0;
      streak_q  <= '0;
`ifdef MEMIO_TIMEOUT_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      f_rdata_q <= f_rdata_d;
      d_rdata_q <= d_rdata_d;
      streak_q  <= streak_d;
`ifdef MEMIO_TIMEOUT_EN
      err_q     <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_memory_arbiter_io.sv
// tb_memory_arbiter_io
// Directed, table-driven bench for memory_arbiter_io with a behavioural
// memory model on the shared bus. With MEMIO_TIMEOUT_EN defined the timeout
// abort path is exercised (TIMEOUT=4); otherwise the indefinite wait is.
module tb_memory_arbiter_io;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] address;
  logic        read_m, write_m, input_ready, busy, err;
  wire  [15:0] data;
  logic        mem_oe;
  logic [15:0] mem_drv;

  memory_arbiter_io_if #(.WIDTH(16)) rif ();

  memory_arbiter_io #(
    .WIDTH  (16),
    .TIMEOUT(4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_if     (rif.slave),
    .address    (address),
    .read_m     (read_m),
    .write_m    (write_m),
    .data       (data),
    .input_ready(input_ready),
    .busy       (busy),
    .err        (err)
  );

  assign data = mem_oe ? mem_drv : 'z;

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          mem_delay = 0;
  int          acc_k = 0;
  logic        ir_force = 1'b0;
  logic [15:0] mem [0:255];
  logic [15:0] gl [$];

  typedef struct {
    bit          is_d;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          delay;
    int          exp_lat;
    logic [15:0] exp_f;
    logic [15:0] exp_d;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: completes the k-th ACCESS cycle once k >= mem_delay,
  // returns stored words on reads, commits bus data on writes, and logs the
  // address of every new access as its grant.
  initial begin
    input_ready = 1'b0;
    mem_oe      = 1'b0;
    mem_drv     = '0;
    forever begin
      @(posedge clk);
      #1;
      if (read_m || write_m) begin
        if (acc_k == 0) gl.push_back(address);
        if (acc_k >= mem_delay) begin
          input_ready = 1'b1;
          if (write_m) begin
            mem[address[7:0]] = data;
            mem_oe = 1'b0;
          end else begin
            mem_drv = mem[address[7:0]];
            mem_oe  = 1'b1;
          end
        end else begin
          input_ready = 1'b0;
          mem_oe      = 1'b0;
        end
        acc_k++;
      end else begin
        acc_k       = 0;
        input_ready = ir_force;
        mem_oe      = 1'b0;
      end
    end
  end

  // One request from IDLE until its ack (bounded), then one settling cycle.
  task automatic run_txn(input bit is_d, input bit we,
                         input logic [15:0] addr, input logic [15:0] wdata,
                         output int lat, output int rd, output int wr,
                         output bit bus_ok, output bit fa, output bit da,
                         output bit er);
    lat = 0; rd = 0; wr = 0; bus_ok = 1'b1; fa = 1'b0; da = 1'b0; er = 1'b0;
    if (is_d) begin
      rif.d_req = 1'b1; rif.d_we = we; rif.d_addr = addr; rif.d_wdata = wdata;
    end else begin
      rif.f_req = 1'b1; rif.f_addr = addr;
    end
    while (lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (read_m) rd++;
      if (write_m) begin
        wr++;
        if (data !== wdata) bus_ok = 1'b0;
      end
      if (rif.f_ack || rif.d_ack) begin
        fa = rif.f_ack;
        da = rif.d_ack;
        er = err;
        if (is_d && we && (data === wdata)) bus_ok = 1'b0;
        break;
      end
    end
    rif.f_req = 1'b0;
    rif.d_req = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int lat, rd, wr, fac, dac;
    bit ok, fa, da, er;
    logic [15:0] exp_order [6];

    reset_n     = 1'b0;
    rif.f_req   = 1'b0;
    rif.f_addr  = '0;
    rif.d_req   = 1'b0;
    rif.d_we    = 1'b0;
    rif.d_addr  = '0;
    rif.d_wdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h10] = 16'h1234;
    mem[8'h30] = 16'hCAFE;
    mem[8'h40] = 16'h4444;
    mem[8'h50] = 16'h5555;

    //          is_d we  addr      wdata     dly lat f_rdata   d_rdata
    vecs[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 0, 2, 16'h1234, 16'h0000};
    vecs[1] = '{1'b1, 1'b1, 16'h0020, 16'hBEEF, 3, 5, 16'h1234, 16'h0000};
    vecs[2] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 1, 3, 16'h1234, 16'hBEEF};
    vecs[3] = '{1'b0, 1'b0, 16'h0030, 16'h0000, 2, 4, 16'hCAFE, 16'hBEEF};
    vecs[4] = '{1'b1, 1'b1, 16'h0030, 16'h0001, 0, 2, 16'hCAFE, 16'hBEEF};
    vecs[5] = '{1'b0, 1'b0, 16'h0030, 16'h0000, 0, 2, 16'h0001, 16'hBEEF};
    vecs[6] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 0, 2, 16'h0001, 16'h1234};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_strobes", {28'd0, read_m, write_m, busy, err}, 32'd0);
    chk("rst_acks", {30'd0, rif.f_ack, rif.d_ack}, 32'd0);
    chk("rst_addr", {16'd0, address}, 32'd0);
    chk("rst_rdata", {rif.f_rdata, rif.d_rdata}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Single transactions
    for (int i = 0; i < 7; i++) begin
      mem_delay = vecs[i].delay;
      run_txn(vecs[i].is_d, vecs[i].we, vecs[i].addr, vecs[i].wdata,
              lat, rd, wr, ok, fa, da, er);
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
      chk($sformatf("vec%0d_ack", i), {30'd0, fa, da},
          vecs[i].is_d ? 32'd1 : 32'd2);
      chk($sformatf("vec%0d_err", i), {31'd0, er}, 32'd0);
      if (vecs[i].is_d && vecs[i].we) begin
        chk($sformatf("vec%0d_wr_cycles", i), wr, vecs[i].delay + 1);
        chk($sformatf("vec%0d_rd_cycles", i), rd, 0);
        chk($sformatf("vec%0d_bus", i), {31'd0, ok}, 32'd1);
      end else begin
        chk($sformatf("vec%0d_rd_cycles", i), rd, vecs[i].delay + 1);
        chk($sformatf("vec%0d_wr_cycles", i), wr, 0);
      end
      chk($sformatf("vec%0d_f_rdata", i), {16'd0, rif.f_rdata}, {16'd0, vecs[i].exp_f});
      chk($sformatf("vec%0d_d_rdata", i), {16'd0, rif.d_rdata}, {16'd0, vecs[i].exp_d});
    end

    // input_ready while IDLE, then while DONE
    ir_force = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("idle_ir%0d", i),
          {28'd0, busy, read_m, rif.f_ack, rif.d_ack}, 32'd0);
    end
    mem_delay = 0;
    run_txn(1'b0, 1'b0, 16'h0040, 16'h0000, lat, rd, wr, ok, fa, da, er);
    chk("done_ir_lat", lat, 2);
    chk("done_ir_ack", {30'd0, fa, da}, 32'd2);
    chk("done_ir_after", {29'd0, busy, rif.f_ack, rif.d_ack}, 32'd0);
    ir_force = 1'b0;

    // Both requests held: D, D, F, D, D, F at one access per 3 cycles
    gl.delete();
    exp_order = '{16'h0050, 16'h0050, 16'h0040, 16'h0050, 16'h0050, 16'h0040};
    mem_delay = 0;
    fac = 0;
    dac = 0;
    rif.f_addr = 16'h0040;
    rif.d_addr = 16'h0050;
    rif.d_we   = 1'b0;
    rif.f_req  = 1'b1;
    rif.d_req  = 1'b1;
    for (int c = 0; c < 18; c++) begin
      @(posedge clk);
      #1;
      if (rif.f_ack) fac++;
      if (rif.d_ack) dac++;
    end
    rif.f_req = 1'b0;
    rif.d_req = 1'b0;
    @(posedge clk);
    #1;
    chk("arb_grants", gl.size(), 6);
    for (int g = 0; g < 6; g++) begin
      chk($sformatf("arb_order%0d", g), {16'd0, gl[g]}, {16'd0, exp_order[g]});
    end
    chk("arb_f_acks", fac, 2);
    chk("arb_d_acks", dac, 4);
    chk("arb_rdata", {rif.f_rdata, rif.d_rdata}, {16'h4444, 16'h5555});

`ifdef MEMIO_TIMEOUT_EN
    // Memory never answers: abort after 4 ACCESS cycles
    mem_delay = 1000;
    run_txn(1'b1, 1'b0, 16'h0010, 16'h0000, lat, rd, wr, ok, fa, da, er);
    chk("to_lat", lat, 5);
    chk("to_rd_cycles", rd, 4);
    chk("to_ack", {30'd0, fa, da}, 32'd1);
    chk("to_err", {31'd0, er}, 32'd1);
    chk("to_err_after", {31'd0, err}, 32'd0);
    chk("to_d_rdata", {16'd0, rif.d_rdata}, 32'h5555);
`else
    // Memory never answers: stays in ACCESS, no err, no ack
    mem_delay = 1000;
    rif.d_req  = 1'b1;
    rif.d_we   = 1'b0;
    rif.d_addr = 16'h0010;
    @(posedge clk);
    #1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("nto_wait%0d", c),
          {28'd0, read_m, busy, err, rif.d_ack}, 32'hC);
    end
    chk("nto_d_rdata", {16'd0, rif.d_rdata}, 32'h5555);
    reset_n = 1'b0;
    rif.d_req = 1'b0;
    #10;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
`endif

    // Reset asserted mid-ACCESS of a load
    mem_delay  = 1000;
    rif.d_req  = 1'b1;
    rif.d_we   = 1'b0;
    rif.d_addr = 16'h0020;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rst_pre", {30'd0, read_m, busy}, 32'd3);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_strobes", {29'd0, read_m, write_m, busy}, 32'd0);
    chk("mid_rst_addr", {16'd0, address}, 32'd0);
    rif.d_req = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("mid_rst_noack%0d", c), {30'd0, rif.f_ack, rif.d_ack}, 32'd0);
    end
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_rdata", {rif.f_rdata, rif.d_rdata}, 32'd0);
    mem_delay = 0;
    run_txn(1'b0, 1'b0, 16'h0010, 16'h0000, lat, rd, wr, ok, fa, da, er);
    chk("post_rst_lat", lat, 2);
    chk("post_rst_ack", {30'd0, fa, da}, 32'd2);
    chk("post_rst_f_rdata", {16'd0, rif.f_rdata}, 32'h1234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
